// File: rtl/shared_reg_arbiter_amisha.sv
// shared_reg_arbiter_amisha
// Round-robin arbiter in front of a single shared WIDTH-bit register.
// At most one requester writes per cycle. A requester that wins while
// holding its lock keeps exclusive ownership until the lock drops.
module shared_reg_arbiter_amisha #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_amisha,
    input  logic                     rst_n_amisha,
    input  logic [N_REQ-1:0]         req_amisha,
    input  logic [N_REQ-1:0]         lock_amisha,
    input  logic [N_REQ*WIDTH-1:0]   d_amisha,
    output logic [WIDTH-1:0]         q_amisha,
    output logic [N_REQ-1:0]         gnt_amisha,
    output logic                     wr_ack_amisha,
    output logic                     busy_amisha,
    output logic [$clog2(N_REQ)-1:0] owner_amisha
);

    localparam int PW = $clog2(N_REQ);
    localparam logic [PW:0] NREQ_C = (PW+1)'(N_REQ);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     owner_q;
    logic [WIDTH-1:0]  q_q;
    logic [N_REQ-1:0]  gnt_q;
    logic              wr_ack_q;
    logic              busy_q;

    logic              found_d;
    logic [PW-1:0]     win_d;
    logic [PW:0]       idx_d;
    logic [WIDTH-1:0]  win_data_d;
    logic [WIDTH-1:0]  own_data_d;

    // Advance a requester index by one, wrapping at N_REQ.
    function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] v);
        logic [PW:0] s;
        s = {1'b0, v} + {{PW{1'b0}}, 1'b1};
        if (s >= NREQ_C) begin
            s = {(PW+1){1'b0}};
        end else begin
            s = s;
        end
        return s[PW-1:0];
    endfunction

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] v);
        logic [N_REQ-1:0] r;
        r = {N_REQ{1'b0}};
        r[v] = 1'b1;
        return r;
    endfunction

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        found_d = 1'b0;
        win_d   = {PW{1'b0}};
        idx_d   = {(PW+1){1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            idx_d = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx_d >= NREQ_C) begin
                idx_d = idx_d - NREQ_C;
            end else begin
                idx_d = idx_d;
            end
            if (!found_d && req_amisha[idx_d[PW-1:0]]) begin
                found_d = 1'b1;
                win_d   = idx_d[PW-1:0];
            end else begin
                found_d = found_d;
            end
        end
    end

    // Data slices of the arbitration winner and of the current owner.
    always_comb begin
        win_data_d = d_amisha[win_d*WIDTH +: WIDTH];
        own_data_d = d_amisha[owner_q*WIDTH +: WIDTH];
    end

    // Ownership FSM together with the shared register and its registered status.
    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            state_q  <= ST_IDLE;
            ptr_q    <= {PW{1'b0}};
            owner_q  <= {PW{1'b0}};
            q_q      <= {WIDTH{1'b0}};
            gnt_q    <= {N_REQ{1'b0}};
            wr_ack_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            gnt_q    <= {N_REQ{1'b0}};
            wr_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        q_q      <= win_data_d;
                        gnt_q    <= onehot(win_d);
                        wr_ack_q <= 1'b1;
                        owner_q  <= win_d;
                        if (lock_amisha[win_d]) begin
                            // Lock taken on the granting edge; pointer frozen.
                            state_q <= ST_OWNED;
                            busy_q  <= 1'b1;
                        end else begin
                            ptr_q <= inc_mod(win_d);
                        end
                    end else begin
                        ptr_q <= ptr_q;
                    end
                end
                ST_OWNED: begin
                    // Only the owner is served; everyone else waits.
                    if (req_amisha[owner_q]) begin
                        q_q      <= own_data_d;
                        gnt_q    <= onehot(owner_q);
                        wr_ack_q <= 1'b1;
                    end else begin
                        q_q <= q_q;
                    end
                    if (!lock_amisha[owner_q]) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        ptr_q   <= inc_mod(owner_q);
                    end else begin
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q_amisha      = q_q;
    assign gnt_amisha    = gnt_q;
    assign wr_ack_amisha = wr_ack_q;
    assign busy_amisha   = busy_q;
    assign owner_amisha  = owner_q;

endmodule
